// File: rtl/block_pkg.sv
// ============================================================================
//  Module : block_pkg
//  Brief  : Shared types and constants for the indexed bit block writer/reader
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package block_pkg;

  localparam int BLOCK_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } block_state_e;

endpackage

`default_nettype wire

// File: rtl/block_bit_writer.sv
// ============================================================================
//  Module : block_bit_writer
//  Brief  : Fills a DEPTH-bit block one bit per handshake from start_idx up to
//           DEPTH-1, then holds the block with block_valid until block_ack.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module block_bit_writer
  import block_pkg::*;
#(
  parameter  int DEPTH = BLOCK_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [IDX_W-1:0] wr_idx,
  output logic             busy,
  output logic [DEPTH-1:0] block_out,
  output logic             block_valid,
  input  logic             block_ack
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  block_state_e     state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [DEPTH-1:0] block_q, block_d;
  logic             start_ok;

  // Out-of-range start indices only exist when DEPTH is not a power of two.
  assign start_ok = (32'(start_idx) < DEPTH);

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    block_d  = block_q;
    case (state_q)
      IDLE: begin
        if (start && start_ok) begin
          wr_idx_d = start_idx;
          state_d  = FILL;
        end
      end
      FILL: begin
        // abort takes priority over a coincident handshake
        if (abort) begin
          state_d = IDLE;
        end else if (bit_valid) begin
          block_d[wr_idx_q] = bit_in;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = FULL;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (block_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      block_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      block_q  <= block_d;
    end
  end

  assign bit_ready   = (state_q == FILL);
  assign block_valid = (state_q == FULL);
  assign busy        = (state_q != IDLE);
  assign wr_idx      = wr_idx_q;
  assign block_out   = block_q;

endmodule

`default_nettype wire

// File: tb/tb_block_bit_writer.sv
// ============================================================================
//  Module : tb_block_bit_writer
//  Brief  : Self-checking bench for block_bit_writer (DEPTH 64 and 48)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_block_bit_writer;

  logic        clk = 1'b0;
  logic        rst, start, abort, bit_in, bit_valid, block_ack;
  logic [5:0]  start_idx;
  logic        bit_ready, busy, block_valid;
  logic [5:0]  wr_idx;
  logic [63:0] block_out;

  logic        s_rst, s_start, s_abort, s_bit_in, s_bit_valid, s_block_ack;
  logic [5:0]  s_start_idx;
  logic        s_bit_ready, s_busy, s_block_valid;
  logic [5:0]  s_wr_idx;
  logic [47:0] s_block_out;

  always #5 clk = ~clk;

  block_bit_writer #(.DEPTH(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .start_idx(start_idx), .abort(abort),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .wr_idx(wr_idx), .busy(busy), .block_out(block_out),
    .block_valid(block_valid), .block_ack(block_ack)
  );

  block_bit_writer #(.DEPTH(48)) u_dut48 (
    .clk(clk), .rst(s_rst), .start(s_start), .start_idx(s_start_idx), .abort(s_abort),
    .bit_in(s_bit_in), .bit_valid(s_bit_valid), .bit_ready(s_bit_ready),
    .wr_idx(s_wr_idx), .busy(s_busy), .block_out(s_block_out),
    .block_valid(s_block_valid), .block_ack(s_block_ack)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the block as an array of bits, a mode and a write pointer.
  bit          m_blk[64];
  int          m_idx;
  int          m_mode;           // 0 idle, 1 filling, 2 holding a full block
  logic [63:0] exp_q[$];

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    for (int k = 0; k < 64; k++) v[k] = m_blk[k];
    return v;
  endfunction

  // Monitor: every rising block_valid must match the next predicted block.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (block_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block_valid", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_block_out", block_out, e);
        chk("sb_wr_idx", 64'(wr_idx), 64'd0);
      end
    end
    prev_valid <= block_valid;
  end

  task automatic cycle(input bit r, input bit st, input int sidx, input bit ab,
                       input bit bv, input bit bi, input bit ak);
    rst = r; start = st; start_idx = 6'(sidx); abort = ab;
    bit_valid = bv; bit_in = bi; block_ack = ak;
    @(posedge clk); #1;
    if (r) begin
      foreach (m_blk[k]) m_blk[k] = 1'b0;
      m_idx = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (st) begin m_idx = sidx % 64; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (ab) m_mode = 0;
      else if (bv) begin
        m_blk[m_idx] = bi;
        if (m_idx == 63) begin
          m_idx = 0; m_mode = 2;
          exp_q.push_back(m_pack());
        end else m_idx++;
      end
    end else if (ak) begin
      m_mode = 0;
    end
    rst = 0; start = 0; abort = 0; bit_valid = 0; block_ack = 0;
    chk("busy", 64'(busy), 64'(m_mode != 0));
    chk("bit_ready", 64'(bit_ready), 64'(m_mode == 1));
    chk("block_valid", 64'(block_valid), 64'(m_mode == 2));
    chk("wr_idx", 64'(wr_idx), 64'(m_idx));
    chk("block_out", block_out, m_pack());
  endtask

  task automatic send_bits(input logic [63:0] pat, input int from, input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1, pat[from + i], 0);
  endtask

  task automatic cycle48(input bit r, input bit st, input int sidx, input bit bv, input bit bi);
    s_rst = r; s_start = st; s_start_idx = 6'(sidx); s_bit_valid = bv; s_bit_in = bi;
    @(posedge clk); #1;
    s_rst = 0; s_start = 0; s_bit_valid = 0;
  endtask

  initial begin
    logic [63:0] pat;
    rst = 1; start = 0; start_idx = '0; abort = 0; bit_in = 0; bit_valid = 0; block_ack = 0;
    s_rst = 1; s_start = 0; s_start_idx = '0; s_abort = 0; s_bit_in = 0;
    s_bit_valid = 0; s_block_ack = 0;
    m_idx = 0; m_mode = 0;

    // T1: full fill of the A5 pattern from index 0
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("reset_block_out", block_out, 64'd0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    pat = 64'hA5A5_A5A5_A5A5_A5A5;
    send_bits(pat, 0, 64);
    chk("t1_block_out", block_out, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_block_valid", 64'(block_valid), 64'd1);
    cycle(0, 1, 5, 1, 1, 0, 0);        // start/abort/bits ignored while FULL
    cycle(0, 0, 0, 0, 0, 0, 1);        // ack
    chk("t1_ack_valid", 64'(block_valid), 64'd0);

    // T2: partial fill of the top four bits
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 60, 0, 0, 0, 0);
    send_bits(64'hF, 0, 4);
    chk("t2_block_out", block_out, 64'hF000_0000_0000_0000);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // T3: gapped bit_valid
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0, (i % 3) == 0, 1'($urandom), 0);
    chk("t3_wr_idx", 64'(wr_idx), 64'd14);

    // T4: abort coinciding with a handshake
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    send_bits(64'h3FF, 0, 10);
    cycle(0, 0, 0, 1, 1, 1, 0);
    chk("t4_block_out", block_out, 64'h3FF);
    chk("t4_wr_idx", 64'(wr_idx), 64'd10);
    chk("t4_busy", 64'(busy), 64'd0);

    // T5: reset from FULL, then ack from FULL, then start+ack together
    cycle(0, 1, 0, 0, 0, 0, 0);
    send_bits({$urandom, $urandom} | 64'h1, 0, 64);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("t5_rst_block_out", block_out, 64'd0);
    chk("t5_rst_valid", 64'(block_valid), 64'd0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    send_bits({$urandom, $urandom}, 0, 64);
    cycle(0, 1, 3, 0, 0, 0, 1);
    chk("t5_start_ack_busy", 64'(busy), 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("t5_still_idle", 64'(busy), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++)
      cycle(0, ($urandom % 4) == 0, 32 + ($urandom % 32), ($urandom % 60) == 0,
            ($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // T6: DEPTH=48, out-of-range start and top-index fill
    cycle48(1, 0, 0, 0, 0);
    chk("t6_reset_busy", 64'(s_busy), 64'd0);
    cycle48(0, 1, 50, 0, 0);
    chk("t6_oob_busy", 64'(s_busy), 64'd0);
    chk("t6_oob_ready", 64'(s_bit_ready), 64'd0);
    cycle48(0, 1, 47, 0, 0);
    chk("t6_start_idx", 64'(s_wr_idx), 64'd47);
    chk("t6_ready", 64'(s_bit_ready), 64'd1);
    cycle48(0, 0, 0, 1, 1);
    chk("t6_valid", 64'(s_block_valid), 64'd1);
    chk("t6_block_out", 64'(s_block_out), 64'h8000_0000_0000);
    chk("t6_wr_idx", 64'(s_wr_idx), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
